// File: rtl/edm_wide_pkg.sv
// Shared types and width helpers for the edm_wide Sobel edge-detection master.
// Optional feature macro: EDM_THRESHOLD_EN (binarised output against a threshold).
package edm_pkg;

    // Externally visible mode code on ED_mode.
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_DONE  = 2'b11
    } ed_mode_t;

    // Internal controller state.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FILL,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    // Bits of one 3-row window holding n_out+2 pixels per row.
    function automatic int win_w(input int n_out, input int pix_w);
        return 3 * (n_out + 2) * pix_w;
    endfunction

    // Signed gradient width: 4*max pixel plus sign.
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    // Unsaturated |Gx|+|Gy| width.
    function automatic int mag_w(input int pix_w);
        return pix_w + 4;
    endfunction

endpackage

// File: rtl/edm_wide_sobel_kernel.sv
// Combinational Sobel operator: one 3x3 neighbourhood in, one PIX_W result out.
// With EDM_THRESHOLD_EN the result is binarised against threshold; otherwise it is
// the magnitude saturated to the pixel range.
module sobel_kernel
    import edm_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [2:0][2:0][PIX_W-1:0] pix,   // pix[row][col], row 0 is top
`ifdef EDM_THRESHOLD_EN
    input  logic [PIX_W-1:0]           threshold,
`endif
    output logic [PIX_W-1:0]           result
);

    localparam int GW = grad_w(PIX_W);
    localparam int MW = mag_w(PIX_W);
    localparam logic [MW-1:0] PIX_MAX = MW'((2 ** PIX_W) - 1);

    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [MW-1:0]        ax;
    logic [MW-1:0]        ay;
    logic [MW-1:0]        mag;

    // Zero-extend a pixel into the signed gradient domain.
    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
        return $signed(GW'(v));
    endfunction

    // Gradients, absolute values and the final per-pixel result.
    always_comb begin
        gx = (ext(pix[0][2]) + (ext(pix[1][2]) <<< 1) + ext(pix[2][2]))
           - (ext(pix[0][0]) + (ext(pix[1][0]) <<< 1) + ext(pix[2][0]));
        gy = (ext(pix[2][0]) + (ext(pix[2][1]) <<< 1) + ext(pix[2][2]))
           - (ext(pix[0][0]) + (ext(pix[0][1]) <<< 1) + ext(pix[0][2]));
        ax  = MW'($unsigned(gx[GW-1] ? -gx : gx));
        ay  = MW'($unsigned(gy[GW-1] ? -gy : gy));
        mag = ax + ay;
`ifdef EDM_THRESHOLD_EN
        result = (mag >= MW'(threshold)) ? '1 : '0;
`else
        result = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
`endif
    end

endmodule

// File: rtl/edm_wide.sv
// edm_wide: Sobel edge-detection master. Walks the image in 3-row windows of N_OUT+2
// pixels, fetching each over fill_buff/buff_filled, computing N_OUT magnitudes in one
// cycle and writing them back over ED_dfb. The last window of a row is clamped to the
// right edge, so a few outputs may be rewritten with identical values.
// Optional feature macro: EDM_THRESHOLD_EN adds the threshold port and binarised output.
module edm_wide
    import edm_pkg::*;
#(
    parameter int N_OUT = 2,
    parameter int PIX_W = 8,
    parameter int DIM_W = 12,
    parameter int ADR_W = 20
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             ED_start,
    input  logic [DIM_W-1:0]                 image_width,
    input  logic [DIM_W-1:0]                 image_height,
    input  logic                             buff_filled,
    input  logic [win_w(N_OUT, PIX_W)-1:0]   ED_rdata,
    input  logic                             ED_dfb,
`ifdef EDM_THRESHOLD_EN
    input  logic [PIX_W-1:0]                 threshold,
`endif
    output logic                             fill_buff,
    output logic                             ED_done,
    output logic [1:0]                       ED_mode,
    output logic [ADR_W-1:0]                 ED_rpixnum,
    output logic [ADR_W-1:0]                 ED_wpixnum,
    output logic [N_OUT*PIX_W-1:0]           ED_wdata
);

    localparam int WINC  = N_OUT + 2;
    localparam int WIN_W = win_w(N_OUT, PIX_W);
    localparam int DW1   = DIM_W + 1;
    localparam logic [DIM_W:0] STEP = DW1'(N_OUT);
    localparam logic [DIM_W:0] WSPAN = DW1'(WINC);
    localparam logic [DIM_W:0] THREE = DW1'(3);

    state_t               state;
    logic [DIM_W-1:0]     row;
    logic [DIM_W-1:0]     col;
    logic [DIM_W-1:0]     width_q;
    logic [DIM_W-1:0]     height_q;
    logic [WIN_W-1:0]     win;
    logic [N_OUT*PIX_W-1:0] res;

    logic [DIM_W:0]       col_adv;
    logic [DIM_W:0]       last_col;
    logic [DIM_W:0]       nrow;
    logic [DIM_W-1:0]     ncol;
    logic                 finish;
    logic [ADR_W-1:0]     next_rpix;

    // One kernel per output pixel; output k sees window columns k..k+2.
    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        logic [2:0][2:0][PIX_W-1:0] tap;
        for (genvar r = 0; r < 3; r++) begin : g_r
            for (genvar c = 0; c < 3; c++) begin : g_c
                assign tap[r][c] = win[(r*WINC + k + c)*PIX_W +: PIX_W];
            end
        end
        sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
            .pix       (tap),
`ifdef EDM_THRESHOLD_EN
            .threshold (threshold),
`endif
            .result    (res[k*PIX_W +: PIX_W])
        );
    end

    // Next window position: step right, clamp to the edge once, then wrap to next row.
    always_comb begin
        col_adv  = {1'b0, col} + STEP;
        last_col = {1'b0, width_q} - WSPAN;
        nrow     = {1'b0, row};
        ncol     = col_adv[DIM_W-1:0];
        if (col_adv + WSPAN > {1'b0, width_q}) begin
            if ({1'b0, col} == last_col) begin
                nrow = {1'b0, row} + 1'b1;
                ncol = '0;
            end else begin
                ncol = last_col[DIM_W-1:0];
            end
        end
        finish    = (nrow + THREE) > {1'b0, height_q};
        next_rpix = ADR_W'(nrow[DIM_W-1:0]) * ADR_W'(width_q) + ADR_W'(ncol);
    end

    // Controller FSM with registered handshake, address and data outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            width_q    <= '0;
            height_q   <= '0;
            win        <= '0;
            fill_buff  <= 1'b0;
            ED_done    <= 1'b0;
            ED_mode    <= MODE_IDLE;
            ED_rpixnum <= '0;
            ED_wpixnum <= '0;
            ED_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ED_start) begin
                        width_q  <= image_width;
                        height_q <= image_height;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ({1'b0, width_q} < WSPAN || {1'b0, height_q} < THREE) begin
                        ED_done <= 1'b1;
                        ED_mode <= MODE_DONE;
                        state   <= S_DONE;
                    end else begin
                        row        <= '0;
                        col        <= '0;
                        ED_rpixnum <= '0;
                        fill_buff  <= 1'b1;
                        ED_mode    <= MODE_READ;
                        state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (buff_filled) begin
                        win       <= ED_rdata;
                        fill_buff <= 1'b0;
                        state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    ED_wdata   <= res;
                    ED_wpixnum <= ED_rpixnum + ADR_W'(width_q) + ADR_W'(1);
                    ED_mode    <= MODE_WRITE;
                    state      <= S_WRITE;
                end
                S_WRITE: begin
                    if (ED_dfb) begin
                        if (finish) begin
                            ED_done <= 1'b1;
                            ED_mode <= MODE_DONE;
                            state   <= S_DONE;
                        end else begin
                            row        <= nrow[DIM_W-1:0];
                            col        <= ncol;
                            ED_rpixnum <= next_rpix;
                            fill_buff  <= 1'b1;
                            ED_mode    <= MODE_READ;
                            state      <= S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    if (!ED_start) begin
                        ED_done <= 1'b0;
                        ED_mode <= MODE_IDLE;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edm_wide.sv
// Scoreboard bench for edm_wide: expected write records are pushed when a window is
// served and popped when the DUT presents a write. Expected fetch addresses come from
// an independent enumeration of window positions.
module tb_edm_wide;

    localparam int N_OUT = 2;
    localparam int PIX_W = 8;
    localparam int DIM_W = 12;
    localparam int ADR_W = 20;
    localparam int WINC  = N_OUT + 2;
    localparam int WIN_W = 3 * WINC * PIX_W;

    logic                   clk = 1'b0;
    logic                   n_rst = 1'b0;
    logic                   ED_start = 1'b0;
    logic [DIM_W-1:0]       image_width = '0;
    logic [DIM_W-1:0]       image_height = '0;
    logic                   buff_filled = 1'b0;
    logic [WIN_W-1:0]       ED_rdata = '0;
    logic                   ED_dfb = 1'b0;
`ifdef EDM_THRESHOLD_EN
    logic [PIX_W-1:0]       threshold = 8'd50;
`endif
    logic                   fill_buff;
    logic                   ED_done;
    logic [1:0]             ED_mode;
    logic [ADR_W-1:0]       ED_rpixnum;
    logic [ADR_W-1:0]       ED_wpixnum;
    logic [N_OUT*PIX_W-1:0] ED_wdata;

    edm_wide #(.N_OUT(N_OUT), .PIX_W(PIX_W), .DIM_W(DIM_W), .ADR_W(ADR_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .ED_start     (ED_start),
        .image_width  (image_width),
        .image_height (image_height),
        .buff_filled  (buff_filled),
        .ED_rdata     (ED_rdata),
        .ED_dfb       (ED_dfb),
`ifdef EDM_THRESHOLD_EN
        .threshold    (threshold),
`endif
        .fill_buff    (fill_buff),
        .ED_done      (ED_done),
        .ED_mode      (ED_mode),
        .ED_rpixnum   (ED_rpixnum),
        .ED_wpixnum   (ED_wpixnum),
        .ED_wdata     (ED_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wpix;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          rq[$];
    logic [7:0]  img [0:63];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_wdata;
    logic [31:0] last_wpix;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference Sobel for window top-left (r,c), output k.
    function automatic int model_pix(input int w, input int r, input int c, input int k);
        int p[3][3];
        int gx, gy, mag;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = int'(img[(r + i) * w + c + k + j]);
        gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef EDM_THRESHOLD_EN
        return (mag >= int'(threshold)) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    // Drive one complete run and service every fetch/write; counts are returned.
    task automatic run_image(input int w, input int h, input int max_cyc,
                             output int fills, output int writes, output int cycles);
        int dly, rp, exp_rp, r, c;
        exp_t e;
        rq.delete();
        sb.delete();
        if (w >= WINC && h >= 3) begin
            for (int rr = 0; rr <= h - 3; rr++) begin
                int cc = 0;
                forever begin
                    rq.push_back(rr * w + cc);
                    if (cc == w - WINC) break;
                    cc += N_OUT;
                    if (cc > w - WINC) cc = w - WINC;
                end
            end
        end
        image_width  = DIM_W'(w);
        image_height = DIM_W'(h);
        ED_start = 1'b1;
        fills = 0; writes = 0; cycles = 0;
        dly = $urandom_range(0, 2);
        while (cycles < max_cyc) begin
            @(posedge clk); #1;
            cycles++;
            buff_filled = 1'b0;
            ED_dfb = 1'b0;
            if (ED_done) break;
            if (fill_buff) begin
                if (dly > 0) begin
                    dly--;
                    ED_dfb = 1'b1;          // stray accept, must be ignored in FILL
                end else begin
                    fills++;
                    rp = int'(ED_rpixnum);
                    exp_rp = (rq.size() > 0) ? rq.pop_front() : -1;
                    chk("rpixnum", ED_rpixnum, exp_rp);
                    r = rp / w; c = rp % w;
                    ED_rdata = '0;
                    if (r + 2 < h && c + WINC <= w) begin
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < WINC; j++)
                                ED_rdata[(i * WINC + j) * PIX_W +: PIX_W] = img[(r + i) * w + c + j];
                        e.wpix  = rp + w + 1;
                        e.wdata = (model_pix(w, r, c, 1) << 8) | model_pix(w, r, c, 0);
                        sb.push_back(e);
                    end
                    buff_filled = 1'b1;
                    dly = $urandom_range(0, 2);
                end
            end else if (ED_mode == 2'b10) begin
                if (dly > 0) begin
                    dly--;
                    buff_filled = 1'b1;     // stray data valid, must be ignored in WRITE
                end else begin
                    writes++;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("wpixnum", ED_wpixnum, e.wpix);
                        chk("wdata", ED_wdata, e.wdata);
                    end else begin
                        chk("sb_pending", sb.size(), 1);
                    end
                    last_wdata = 32'(ED_wdata);
                    last_wpix  = 32'(ED_wpixnum);
                    ED_dfb = 1'b1;
                    dly = $urandom_range(0, 2);
                end
            end
        end
        chk("done_reached", ED_done, 1);
        chk("rq_left", rq.size(), 0);
        chk("sb_left", sb.size(), 0);
    endtask

    // Hold start in DONE, then release and expect a return to idle.
    task automatic end_run();
        repeat (2) @(posedge clk);
        #1;
        chk("done_hold", {ED_done, ED_mode}, {1'b1, 2'b11});
        ED_start = 1'b0;
        @(posedge clk); #1;
        chk("back_idle", {ED_done, ED_mode}, 3'b000);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fill"}, fill_buff, 0);
        chk({tag, "_done"}, ED_done, 0);
        chk({tag, "_mode"}, ED_mode, 0);
        chk({tag, "_rpix"}, ED_rpixnum, 0);
        chk({tag, "_wpix"}, ED_wpixnum, 0);
        chk({tag, "_wdata"}, ED_wdata, 0);
    endtask

    initial begin
        int f, wr, cy, t;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Step edge: rows 0,1 dark, row 2 bright.
        for (int i = 0; i < 12; i++) img[i] = (i >= 8) ? 8'd255 : 8'd0;
        run_image(4, 3, 200, f, wr, cy);
        chk("step_fills", f, 1);
        chk("step_writes", wr, 1);
        chk("step_wdata", last_wdata, 32'h0000FFFF);
        chk("step_wpix", last_wpix, 5);
        end_run();

        // Flat image: zero gradient, one fetch.
        for (int i = 0; i < 12; i++) img[i] = 8'd100;
        run_image(4, 3, 200, f, wr, cy);
        chk("flat_fills", f, 1);
        chk("flat_wdata", last_wdata, 0);
        end_run();

        // Column ramp giving magnitudes 40 and 60.
        for (int i = 0; i < 12; i++) img[i] = ((i % 4) == 2) ? 8'd10 : (((i % 4) == 3) ? 8'd15 : 8'd0);
        run_image(4, 3, 200, f, wr, cy);
`ifdef EDM_THRESHOLD_EN
        chk("ramp_wdata", last_wdata, 32'h0000FF00);
`else
        chk("ramp_wdata", last_wdata, 32'h00003C28);
`endif
        end_run();

        // 7x4 random image: clamped windows, six writes.
        for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
        run_image(7, 4, 400, f, wr, cy);
        chk("w7_fills", f, 6);
        chk("w7_writes", wr, 6);
        end_run();

        // Too narrow / too short: immediate done, no fetch.
        run_image(3, 5, 20, f, wr, cy);
        chk("narrow_fills", f, 0);
        chk("narrow_quick", cy <= 2, 1);
        end_run();
        run_image(4, 2, 20, f, wr, cy);
        chk("short_fills", f, 0);
        end_run();

        // Reset asserted while a write is pending.
        image_width = 12'd7; image_height = 12'd4;
        ED_start = 1'b1;
        t = 0;
        while (ED_mode != 2'b10 && t < 50) begin
            @(posedge clk); #1;
            t++;
            buff_filled = fill_buff;
        end
        chk("reached_write", ED_mode, 2'b10);
        buff_filled = 1'b0;
        n_rst = 1'b0;
        #1;
        check_zero("midrst");
        ED_start = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        run_image(7, 4, 400, f, wr, cy);
        chk("restart_writes", wr, 6);
        end_run();

        // Larger random image for extra scoreboard traffic.
        for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
        run_image(9, 5, 600, f, wr, cy);
        chk("w9_writes", wr, 12);
        end_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
